// File: rtl/exec_pkg.sv
// Shared definitions for the exec_core integer execution core:
// opcodes, FSM state encoding and instruction-field helpers.
package exec_pkg;

  localparam logic [7:0] OpNop  = 8'd0;
  localparam logic [7:0] OpMovi = 8'd1;
  localparam logic [7:0] OpLd   = 8'd2;
  localparam logic [7:0] OpMov  = 8'd3;
  localparam logic [7:0] OpSt   = 8'd4;
  localparam logic [7:0] OpLdr  = 8'd5;
  localparam logic [7:0] OpStr  = 8'd6;
  localparam logic [7:0] OpAdd  = 8'd10;
  localparam logic [7:0] OpSub  = 8'd11;
  localparam logic [7:0] OpAnd  = 8'd12;
  localparam logic [7:0] OpOr   = 8'd13;
  localparam logic [7:0] OpXor  = 8'd14;
  localparam logic [7:0] OpCmp  = 8'd15;
  localparam logic [7:0] OpJmp  = 8'd16;
  localparam logic [7:0] OpJz   = 8'd17;
  localparam logic [7:0] OpJnz  = 8'd18;
  localparam logic [7:0] OpDbg  = 8'd30;
  localparam logic [7:0] OpHalt = 8'd31;

  typedef enum logic [2:0] {
    StFetch,
    StFwait,
    StDecode,
    StMwait,
    StExec,
    StHalt
  } state_e;

  function automatic logic [7:0] instr_op(input logic [31:0] w);
    return w[7:0];
  endfunction

  function automatic logic [7:0] instr_rd(input logic [31:0] w);
    return w[15:8];
  endfunction

  function automatic logic [15:0] instr_imm(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic is_load(input logic [7:0] op);
    return (op == OpLd) || (op == OpLdr);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OpSt) || (op == OpStr);
  endfunction

  function automatic logic writes_reg(input logic [7:0] op);
    return (op == OpMovi) || (op == OpLd) || (op == OpMov) || (op == OpLdr) ||
           ((op >= OpAdd) && (op <= OpXor));
  endfunction

endpackage

// File: rtl/exec_regfile.sv
// NREG x DATA_W register file: two asynchronous read ports, one synchronous
// write port, all entries cleared by the asynchronous reset.
module exec_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned RW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RW-1:0]     raddr_a,
  input  logic [RW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [RW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];

endmodule

// File: rtl/exec_core.sv
// Multi-cycle integer execution core: fetch/decode FSM, ALU and memory port
// handshake. Every output is driven straight from a register.
module exec_core
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rack,
  input  logic              mem_wack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rreq,
  output logic              mem_wreq,
  output logic [ADDR_W-1:0] ip,
  output logic [7:0]        opcode,
  output logic [1:0]        flags,
  output logic              halted,
  output logic [DATA_W-1:0] debug
);

  localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d, rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, mdata_q, mdata_d, wdata_q, wdata_d, debug_q, debug_d;
  logic [ADDR_W-1:0] ip_q, ip_d, addr_q, addr_d;
  logic              rreq_q, rreq_d, wreq_q, wreq_d, halted_q, halted_d;
  logic [1:0]        flags_q, flags_d;

  logic [31:0]       instr;
  logic [DATA_W-1:0] rf_a, rf_b, rf_wdata, alu, imm_data;
  logic [ADDR_W-1:0] imm_addr;
  logic              rf_we, taken, unused_rd;

  assign instr    = 32'(mem_rdata);
  assign imm_data = DATA_W'(imm_q);
  assign imm_addr = ADDR_W'(imm_q);
  // Only the low RW bits of rd select a register; the rest is kept for debug.
  assign unused_rd = ^rd_q;

  exec_regfile #(
    .DATA_W(DATA_W),
    .NREG  (NREG),
    .RW    (RW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .raddr_a(rd_q[RW-1:0]),
    .raddr_b(imm_q[RW-1:0]),
    .rdata_a(rf_a),
    .rdata_b(rf_b),
    .we     (rf_we),
    .waddr  (rd_q[RW-1:0]),
    .wdata  (rf_wdata)
  );

  always_comb begin
    alu = '0;
    case (op_q)
      OpAdd:        alu = a_q + b_q;
      OpSub, OpCmp: alu = a_q - b_q;
      OpAnd:        alu = a_q & b_q;
      OpOr:         alu = a_q | b_q;
      OpXor:        alu = a_q ^ b_q;
      default:      alu = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OpMovi:      rf_wdata = imm_data;
      OpLd, OpLdr: rf_wdata = mdata_q;
      OpMov:       rf_wdata = b_q;
      default:     rf_wdata = alu;
    endcase
  end

  assign rf_we = (state_q == StExec) && writes_reg(op_q);
  assign taken = (op_q == OpJmp) || ((op_q == OpJz) && flags_q[0]) ||
                 ((op_q == OpJnz) && !flags_q[0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StFetch;
      op_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mdata_q  <= '0;
      wdata_q  <= '0;
      debug_q  <= '0;
      ip_q     <= '0;
      addr_q   <= '0;
      rreq_q   <= 1'b0;
      wreq_q   <= 1'b0;
      halted_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mdata_q  <= mdata_d;
      wdata_q  <= wdata_d;
      debug_q  <= debug_d;
      ip_q     <= ip_d;
      addr_q   <= addr_d;
      rreq_q   <= rreq_d;
      wreq_q   <= wreq_d;
      halted_q <= halted_d;
      flags_q  <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:  state_d = StFwait;
      StFwait:  if (mem_rack) state_d = StDecode;
      StDecode: state_d = (is_load(op_q) || is_store(op_q)) ? StMwait : StExec;
      // Only the ack matching the outstanding request completes the access.
      StMwait:  if (wreq_q ? mem_wack : mem_rack) state_d = StExec;
      StExec:   state_d = (op_q == OpHalt) ? StHalt : StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    op_d     = op_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    a_d      = a_q;
    b_d      = b_q;
    mdata_d  = mdata_q;
    wdata_d  = wdata_q;
    debug_d  = debug_q;
    ip_d     = ip_q;
    addr_d   = addr_q;
    rreq_d   = rreq_q;
    wreq_d   = wreq_q;
    halted_d = halted_q;
    flags_d  = flags_q;
    case (state_q)
      StFetch: begin
        addr_d = ip_q;
        rreq_d = 1'b1;
      end
      StFwait: begin
        if (mem_rack) begin
          op_d   = instr_op(instr);
          rd_d   = instr_rd(instr);
          imm_d  = instr_imm(instr);
          rreq_d = 1'b0;
        end
      end
      StDecode: begin
        a_d = rf_a;
        b_d = rf_b;
        case (op_q)
          OpLd:  begin addr_d = imm_addr;         rreq_d = 1'b1; end
          OpLdr: begin addr_d = ADDR_W'(rf_b);    rreq_d = 1'b1; end
          OpSt:  begin addr_d = imm_addr;         wdata_d = rf_a; wreq_d = 1'b1; end
          OpStr: begin addr_d = ADDR_W'(rf_b);    wdata_d = rf_a; wreq_d = 1'b1; end
          default: ;
        endcase
      end
      StMwait: begin
        if (wreq_q && mem_wack) wreq_d = 1'b0;
        if (rreq_q && mem_rack) begin
          rreq_d  = 1'b0;
          mdata_d = mem_rdata;
        end
      end
      StExec: begin
        if ((op_q >= OpAdd) && (op_q <= OpCmp)) flags_d = {alu[DATA_W-1], alu == '0};
        if (op_q == OpDbg) debug_d = a_q;
        if (op_q == OpHalt) halted_d = 1'b1;
        else ip_d = taken ? imm_addr : ip_q + ADDR_W'(3'd4);
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rreq  = rreq_q;
  assign mem_wreq  = wreq_q;
  assign ip        = ip_q;
  assign opcode    = op_q;
  assign flags     = flags_q;
  assign halted    = halted_q;
  assign debug     = debug_q;

endmodule

// File: doc/exec_core.md
# exec_core

Parametrised multi-cycle integer execution core, the successor to the first-generation Phaethon ALU. It fetches 32-bit instructions over a shared request/acknowledge memory port and decodes them. It executes from a register file of configurable width and depth, and adds subtract/logic ops, compare flags, conditional jumps, register-indirect load/store and halt. It sits between the memory arbiter and the debug/LED fabric at the top of the Phaethon design.

## Interface
- DATA_W, 32, register/data width (≥16)
- ADDR_W, 16, memory address width (≤ DATA_W)
- NREG, 16, register count (power of 2, 2..256)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- mem_rdata  input  DATA_W  read data, valid when mem_rack=1
- mem_rack  input  1  read acknowledge
- mem_wack  input  1  write acknowledge
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  write data
- mem_rreq  output  1  read request
- mem_wreq  output  1  write request
- ip  output  ADDR_W  instruction pointer
- opcode  output  8  current opcode (debug)
- flags  output  2  {N,Z}
- halted  output  1  core stopped
- debug  output  DATA_W  setdebug value

## Operation
- Instruction word (low 32 bits of mem_rdata): op=[7:0], rd=[15:8] (low log2(NREG) bits used), imm=[31:16]. rs = imm low log2(NREG) bits. imm is zero-extended to DATA_W and truncated or zero-extended to ADDR_W for addresses.
- States:
  - FETCH: mem_addr←ip, rreq←1 → FWAIT.
  - FWAIT: on rack, latch op/rd/imm, rreq←0 → DECODE.
  - DECODE: latch A=R[rd], B=R[rs]. For op 2/5, start a read → MWAIT. For op 4/6, start a write → MWAIT. Otherwise → EXEC.
  - MWAIT: on rack (read) or wack (write), drop the request and latch read data → EXEC.
  - EXEC: writeback, update flags/ip → FETCH. Halt → HALT.
  - HALT: terminal; only reset exits.
- Ops:
  - 0 nop
  - 1 R[rd]←imm
  - 2 R[rd]←M[imm]
  - 3 R[rd]←B
  - 4 M[imm]←A
  - 5 R[rd]←M[B]
  - 6 M[B]←A
  - 10 add, 11 sub (A−B), 12 and, 13 or, 14 xor: R[rd]←result, update flags
  - 15 cmp: flags from A−B, no writeback
  - 16 jmp imm
  - 17 jz imm
  - 18 jnz imm
  - 30 debug←A
  - 31 halt
  - Any other opcode is a nop.
- Arithmetic is modulo 2^DATA_W. Z=(result==0), N=result[DATA_W−1]. Flags change only on ops 10–15.
- ip←ip+4 modulo 2^ADDR_W. A taken jump sets ip←imm instead. rd==rs is legal, and A/B are the values latched in DECODE.
- Reset mid-operation aborts immediately: requests drop, state→FETCH, no partial writeback.
- Ack while the matching request is low is ignored. A wrong-type ack in MWAIT (wack on a read, rack on a write) is ignored.

## Timing
- Reset values: all outputs 0, all registers 0, state FETCH, flags 00.
- All outputs are registered. A request is asserted the cycle after issue and held until the ack is sampled. It deasserts the cycle after the ack.
- With same-cycle ack, latencies are:
  - 4 cycles for non-memory ops (FETCH, FWAIT, DECODE, EXEC)
  - 5 cycles for load/store
  - Each extra ack-wait cycle adds 1.
- Register writeback and debug update are visible the cycle after EXEC. ip and flags update on EXEC.
- halted=1 from the cycle after the halt EXEC; no further requests are issued.

## Structure
- Package exec_pkg: opcode localparams, state enum, field slice helpers (op/rd/imm positions).
- Sub-module exec_regfile (NREG×DATA_W, async reset, 2 read ports, 1 write port). The FSM and ALU stay in exec_core.

## Test plan
- Reset, then zero-wait memory with program {mov r1,5; mov r2,3; sub r3,r1,r2} → r3=2, flags=00, ip=12 after 12 cycles.
- cmp r1,r1 then jz 0x40 → flags Z=1, next fetch address 0x40. Repeat with jnz → fetch address ip+4.
- mov r0,0xAB; store [0x20],r0 with wack delayed 3 cycles → wreq high exactly 4 cycles, mem_wdata=0xAB, mem_addr=0x20.
- Indirect load: r2=0x30, M[0x30]=0xDEADBEEF, load r4,[r2] → r4=0xDEADBEEF. Ack pulses asserted while rreq=0 are ignored.
- ip=0xFFFC (ADDR_W=16) executing nop → ip wraps to 0; add 0xFFFFFFFF+1 → result 0, Z=1.
- Reset asserted during MWAIT of a store → wreq drops asynchronously, no register change. halt op → halted=1 and no further rreq.
